// File: rtl/pool2d_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : pool2d_stream_if
//  Purpose  : Pixel stream bundle for the streaming 2-D pooler: the
//             sof/valid input side and the pulsed, framed output side.
//  Ports    : sof, mode, input_valid, d_in       (towards the pooler)
//             output_valid, o_sof, o_eof, d_out  (from the pooler)
//  Revision : 1.0  initial release
// ============================================================================
interface pool2d_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         sof;
  logic                         mode;
  logic                         input_valid;
  logic signed [DATA_WIDTH-1:0] d_in;
  logic                         output_valid;
  logic                         o_sof;
  logic                         o_eof;
  logic signed [DATA_WIDTH-1:0] d_out;

  // slave: the pooler itself
  modport slave (
    input  sof, mode, input_valid, d_in,
    output output_valid, o_sof, o_eof, d_out
  );

  // master: whatever feeds the pooler and consumes its results
  modport master (
    output sof, mode, input_valid, d_in,
    input  output_valid, o_sof, o_eof, d_out
  );
endinterface
`default_nettype wire

// File: rtl/pool2d_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pool2d_stream
//  Purpose  : Streaming KxK max/average pooling with stride S over one
//             raster-scanned single-channel frame. Two-stage pipeline,
//             fixed latency of 2 cycles from the firing pixel.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - pool2d_stream_if.slave (sof/mode/input_valid/d_in in,
//                    output_valid/o_sof/o_eof/d_out out)
//  Revision : 1.0  initial release
// ============================================================================
module pool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 5,
  parameter int IMG_H      = 5,
  parameter int KERNEL     = 2,
  parameter int STRIDE     = 2
) (
  input  logic           clk,
  input  logic           rst,
  pool2d_stream_if.slave bus
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SUM_W  = DATA_WIDTH + 4;
  localparam int PROD_W = DATA_WIDTH + 18;
  localparam int OUT_W  = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int OUT_H  = (IMG_H - KERNEL) / STRIDE + 1;
  // Position of the pixel that completes the last window of a frame
  localparam int LAST_R = KERNEL - 1 + (OUT_H - 1) * STRIDE;
  localparam int LAST_C = KERNEL - 1 + (OUT_W - 1) * STRIDE;

  if (!(KERNEL == 2 || KERNEL == 3)) begin : g_bad_kernel
    $error("pool2d_stream: KERNEL must be 2 or 3");
  end
  if (!(STRIDE == 1 || STRIDE == 2)) begin : g_bad_stride
    $error("pool2d_stream: STRIDE must be 1 or 2");
  end
  if (IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_image
    $error("pool2d_stream: image smaller than the kernel");
  end

  // Position of the next pixel to arrive
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             mode_q;

  // line_buf[0] holds the previous row, line_buf[1] the one before it
  logic signed [DATA_WIDTH-1:0] line_buf [KERNEL-1][IMG_W];
  // win[i][j]: row i = 0 is the oldest row, column j = KERNEL-1 is newest
  logic signed [DATA_WIDTH-1:0] win      [KERNEL][KERNEL];
  logic signed [DATA_WIDTH-1:0] win_nxt  [KERNEL][KERNEL];
  logic signed [DATA_WIDTH-1:0] new_col  [KERNEL];

  logic             accept, start, mid_sof, fire, at_origin;
  logic             first_win, last_win;
  logic [ROW_W-1:0] cur_r, nxt_r;
  logic [COL_W-1:0] cur_c, nxt_c;
  logic signed [SUM_W-1:0]      win_sum;
  logic signed [DATA_WIDTH-1:0] win_max;

  // Stage 1 and stage 2 (output) registers
  logic                         v1, s1_mode, s1_sof, s1_eof;
  logic signed [SUM_W-1:0]      s1_val;
  logic signed [PROD_W-1:0]     prod;
  logic signed [DATA_WIDTH-1:0] scaled;
  logic                         out_valid, out_sof, out_eof;
  logic signed [DATA_WIDTH-1:0] out_data;

  always_comb begin
    accept  = bus.input_valid;
    start   = accept && bus.sof;
    // A sof only aborts work when the previous frame is incomplete
    mid_sof = start && (row != '0 || col != '0);
    cur_r   = start ? '0 : row;
    cur_c   = start ? '0 : col;

    at_origin = (cur_r == '0) && (cur_c == '0);
    first_win = (cur_r == ROW_W'(KERNEL - 1)) && (cur_c == COL_W'(KERNEL - 1));
    last_win  = (cur_r == ROW_W'(LAST_R)) && (cur_c == COL_W'(LAST_C));
    fire = accept
        && (int'(cur_r) >= KERNEL - 1) && (int'(cur_c) >= KERNEL - 1)
        && ((int'(cur_r) - KERNEL + 1) % STRIDE == 0)
        && ((int'(cur_c) - KERNEL + 1) % STRIDE == 0);

    if (cur_c == COL_W'(IMG_W - 1)) begin
      nxt_c = '0;
      nxt_r = (cur_r == ROW_W'(IMG_H - 1)) ? '0 : cur_r + ROW_W'(1);
    end else begin
      nxt_c = cur_c + COL_W'(1);
      nxt_r = cur_r;
    end

    // Column entering the window: current pixel at the bottom, older rows
    // of the same column taken from the line buffers above it.
    new_col[KERNEL-1] = bus.d_in;
    for (int i = 0; i < KERNEL - 1; i++) begin
      new_col[i] = line_buf[KERNEL-2-i][cur_c];
    end

    win_nxt = win;
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL - 1; j++) begin
        win_nxt[i][j] = win[i][j+1];
      end
      win_nxt[i][KERNEL-1] = new_col[i];
    end

    win_sum = '0;
    win_max = win_nxt[0][0];
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL; j++) begin
        win_sum = win_sum + SUM_W'(win_nxt[i][j]);
        if (win_nxt[i][j] > win_max) win_max = win_nxt[i][j];
      end
    end
  end

  // Averaging with round-half-up; 7282/65536 approximates 1/9 for K=3
  always_comb begin
    prod = PROD_W'(s1_val) * PROD_W'(7282) + PROD_W'(32768);
    if (s1_mode) begin
      scaled = s1_val[DATA_WIDTH-1:0];
    end else if (KERNEL == 2) begin
      scaled = DATA_WIDTH'((s1_val + SUM_W'(2)) >>> 2);
    end else begin
      scaled = DATA_WIDTH'(prod >>> 16);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      mode_q    <= 1'b0;
      v1        <= 1'b0;
      s1_mode   <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_val    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        row <= nxt_r;
        col <= nxt_c;
        if (at_origin) mode_q <= bus.mode;
      end

      // The origin pixel never fires, so mode_q is already settled here
      v1 <= fire;
      if (fire) begin
        s1_mode <= mode_q;
        s1_sof  <= first_win;
        s1_eof  <= last_win;
        s1_val  <= mode_q ? SUM_W'(win_max) : win_sum;
      end

      // A mid-frame sof drops the result that would land this cycle
      out_valid <= v1 && !mid_sof;
      out_sof   <= v1 && !mid_sof && s1_sof;
      out_eof   <= v1 && !mid_sof && s1_eof;
      if (v1) out_data <= scaled;
    end
  end

  // Pixel storage carries no reset: stale contents are never read because
  // a window needs K fresh rows of the current frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][cur_c] <= bus.d_in;
      for (int i = 1; i < KERNEL - 1; i++) begin
        line_buf[i][cur_c] <= line_buf[i-1][cur_c];
      end
      win <= win_nxt;
    end
  end

  assign bus.output_valid = out_valid;
  assign bus.o_sof        = out_sof;
  assign bus.o_eof        = out_eof;
  assign bus.d_out        = out_data;

endmodule
`default_nettype wire

// File: tb/tb_pool2d_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool2d_stream
//  Purpose  : Scoreboard bench for pool2d_stream. Two instances: A is a 2x2
//             stride-2 pooler on 4x4 frames, B a 3x3 stride-1 pooler on 5x5
//             frames. A window-level reference model fills per-instance
//             queues; negedge monitors pop and compare every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pool2d_stream;
  localparam int DW = 32;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool2d_stream_if #(.DATA_WIDTH(DW)) ifa ();
  pool2d_stream_if #(.DATA_WIDTH(DW)) ifb ();

  pool2d_stream #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4), .KERNEL(2), .STRIDE(2))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pool2d_stream #(.DATA_WIDTH(DW), .IMG_W(5), .IMG_H(5), .KERNEL(3), .STRIDE(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic signed [DW-1:0] val;
    bit                   sof;
    bit                   eof;
    int                   fire_px;
    longint               stamp;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t plan[$];
  logic signed [DW-1:0] img [0:7][0:7];

  // ---------------- reference model: whole-frame window pooling ----------
  function automatic void build_plan(input int w, input int h, input int k,
                                     input int s, input bit md);
    int ow;
    int oh;
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    plan.delete();
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        longint               sum;
        longint               avg;
        logic signed [DW-1:0] mx;
        exp_t                 e;
        sum = 0;
        mx  = img[oy*s][ox*s];
        for (int dy = 0; dy < k; dy++) begin
          for (int dx = 0; dx < k; dx++) begin
            logic signed [DW-1:0] v;
            v   = img[oy*s+dy][ox*s+dx];
            sum = sum + v;
            if (v > mx) mx = v;
          end
        end
        if (k == 2) avg = (sum + 2) >>> 2;
        else        avg = (sum * 7282 + 32768) >>> 16;
        e.val     = md ? mx : avg[DW-1:0];
        e.sof     = (oy == 0) && (ox == 0);
        e.eof     = (oy == oh - 1) && (ox == ow - 1);
        e.fire_px = (oy * s + k - 1) * w + ox * s + k - 1;
        e.stamp   = 0;
        plan.push_back(e);
      end
    end
  endfunction

  // ---------------- queue helpers ----------------------------------------
  function automatic bit q_empty(input int sel);
    if (sel == 0) return qa.size() == 0;
    return qb.size() == 0;
  endfunction

  function automatic exp_t q_front(input int sel);
    if (sel == 0) return qa[0];
    return qb[0];
  endfunction

  function automatic exp_t q_pop(input int sel);
    if (sel == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  function automatic void q_push(input int sel, input exp_t e);
    if (sel == 0) qa.push_back(e);
    else          qb.push_back(e);
  endfunction

  // Drop expected results that a mid-frame sof accepted at cycle lim aborts
  function automatic void q_flush(input int sel, input longint lim);
    if (sel == 0) begin
      while (qa.size() > 0 && qa[$].stamp >= lim) void'(qa.pop_back());
    end else begin
      while (qb.size() > 0 && qb[$].stamp >= lim) void'(qb.pop_back());
    end
  endfunction

  // ---------------- stimulus ---------------------------------------------
  task automatic set_in(input int sel, input bit v, input bit sf, input bit md,
                        input logic [DW-1:0] d);
    if (sel == 0) begin
      ifa.input_valid = v; ifa.sof = sf; ifa.mode = md; ifa.d_in = d;
    end else begin
      ifb.input_valid = v; ifb.sof = sf; ifb.mode = md; ifb.d_in = d;
    end
  endtask

  task automatic idle(input int n);
    set_in(0, 1'b0, 1'b0, 1'b0, '0);
    set_in(1, 1'b0, 1'b0, 1'b0, '0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_ramp(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) img[r][c] = r * w + c;
  endtask

  task automatic fill_const(input logic signed [DW-1:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = $urandom;
  endtask

  // Streams img row-major; stops before pixel stop_at (-1 = whole frame)
  task automatic drive_frame(input int sel, input int w, input int h,
                             input int k, input int s, input bit md,
                             input bit with_sof, input bit mid_flush,
                             input int max_gap, input int stop_at);
    int   idx;
    exp_t e;
    build_plan(w, h, k, s, md);
    idx = 0;
    if (mid_flush) q_flush(sel, cyc + 1);
    for (int p = 0; p < w * h; p++) begin
      if (p == stop_at) break;
      if (max_gap > 0 && p > 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, max_gap)) begin
          set_in(sel, 1'b0, 1'($urandom), 1'($urandom), $urandom);
          @(posedge clk);
          #1;
        end
      end
      set_in(sel, 1'b1, with_sof && (p == 0), (p == 0) ? md : 1'($urandom),
             img[p / w][p % w]);
      if (idx < plan.size() && plan[idx].fire_px == p) begin
        e       = plan[idx];
        e.stamp = cyc + 2;
        q_push(sel, e);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    set_in(sel, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_idle(input int sel, input string nm);
    logic                 ov, os, oe;
    logic signed [DW-1:0] d;
    if (sel == 0) begin
      ov = ifa.output_valid; os = ifa.o_sof; oe = ifa.o_eof; d = ifa.d_out;
    end else begin
      ov = ifb.output_valid; os = ifb.o_sof; oe = ifb.o_eof; d = ifb.d_out;
    end
    tests++;
    if (ov !== 1'b0 || os !== 1'b0 || oe !== 1'b0 || d !== '0) begin
      fails++;
      $display("FAIL %s: got valid=%0b sof=%0b eof=%0b d_out=%0d, expected all 0",
               nm, ov, os, oe, d);
    end
  endtask

  // ---------------- monitors ---------------------------------------------
  task automatic monitor(input int sel, input bit ov, input bit os, input bit oe,
                         input logic signed [DW-1:0] d);
    exp_t e;
    while (!q_empty(sel)) begin
      e = q_front(sel);
      if (e.stamp >= cyc) break;
      e = q_pop(sel);
      tests++;
      fails++;
      $display("FAIL missing_out dut%0d: no output, expected d_out=%0d at cycle %0d",
               sel, e.val, e.stamp);
    end
    if (ov) begin
      tests++;
      if (q_empty(sel)) begin
        fails++;
        $display("FAIL unexpected_out dut%0d: got d_out=%0d sof=%0b eof=%0b at cycle %0d, expected none",
                 sel, d, os, oe, cyc);
      end else begin
        e = q_pop(sel);
        if (d !== e.val || os !== e.sof || oe !== e.eof || cyc != e.stamp) begin
          fails++;
          $display("FAIL window_out dut%0d: got d_out=%0d sof=%0b eof=%0b cycle=%0d, expected d_out=%0d sof=%0b eof=%0b cycle=%0d",
                   sel, d, os, oe, cyc, e.val, e.sof, e.eof, e.stamp);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitor(0, ifa.output_valid, ifa.o_sof, ifa.o_eof, ifa.d_out);
      monitor(1, ifb.output_valid, ifb.o_sof, ifb.o_eof, ifb.d_out);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------------------------------
  initial begin
    set_in(0, 1'b0, 1'b0, 1'b0, '0);
    set_in(1, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    rst = 1'b0;
    idle(2);

    // Frame 1: 4x4 ramp, 2x2 average -> 3, 5, 11, 13
    fill_ramp(4, 4);
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(4);

    // Frame 2: 5x5 ramp, 3x3 max -> 12..24 interior
    fill_ramp(5, 5);
    drive_frame(1, 5, 5, 3, 1, 1'b1, 1'b1, 1'b0, 0, -1);
    idle(4);

    // Frame 3: rounding and sign
    fill_const(-1);
    drive_frame(1, 5, 5, 3, 1, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(4);
    fill_const(0);
    img[0][0] = 5;
    img[4][4] = 4;
    drive_frame(1, 5, 5, 3, 1, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = (r % 2 == 1 && c % 2 == 1) ? 0 : -1;
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(4);

    // Random full-range frames on both instances, random mode, with gaps
    for (int t = 0; t < 4; t++) begin
      fill_random();
      drive_frame(0, 4, 4, 2, 2, 1'($urandom), 1'b1, 1'b0, 2, -1);
      idle(3);
      fill_random();
      drive_frame(1, 5, 5, 3, 1, 1'($urandom), 1'b1, 1'b0, 2, -1);
      idle(3);
    end

    // Frame 4: frame 1 again with 1-3 cycle input gaps
    fill_ramp(4, 4);
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b0, 3, -1);
    idle(4);

    // Frame 5: sof in place of pixel 6, then a clean frame
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b0, 0, 6);
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b1, 0, -1);
    idle(4);

    // Frame 6: back-to-back frames, mode only taken at pixel (0,0)
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b0, 0, -1);
    drive_frame(0, 4, 4, 2, 2, 1'b1, 1'b0, 1'b0, 0, -1);
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b0, 1'b0, 0, -1);
    idle(4);

    // Reset mid-frame while a window result is in stage 1
    drive_frame(0, 4, 4, 2, 2, 1'b0, 1'b1, 1'b0, 0, 8);
    rst = 1'b1;
    set_in(0, 1'b1, 1'b0, 1'b1, '1);
    qa.delete();
    @(posedge clk);
    #1;
    check_idle(0, "mid_reset_a");
    rst = 1'b0;
    idle(2);
    // After reset the next pixel is (0,0) even without sof
    drive_frame(0, 4, 4, 2, 2, 1'b1, 1'b0, 1'b0, 0, -1);
    idle(10);

    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d results still pending, expected 0/0",
               qa.size(), qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
